iq_frame_packer: RTL and testbench
==================================

IQ_FRAME_PACKER -- requirements
Module: iq_frame_packer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed first as below.
REQ-002 Parameter SAMPLE_W, default 13: I/Q sample width in bits.
REQ-003 Parameter NUM_CH, default 1: IQ channels per sample group, range 1..8.
REQ-004 Parameter GAP_WORDS, default 8: zero words sent before each sample group, range 1..255.
REQ-005 Localparam FRAME_W SHALL equal 2*SAMPLE_W+6.
REQ-006 clk  in  1  system clock; all state on rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  request to begin a message; sampled in IDLE only.
REQ-009 s_valid  in  1  sample group available.
REQ-010 s_last  in  1  qualifies s_valid: this group is the last of the message.
REQ-011 s_i  in  NUM_CH*SAMPLE_W  I samples; channel k at bits [k*SAMPLE_W +: SAMPLE_W].
REQ-012 s_q  in  NUM_CH*SAMPLE_W  Q samples, same packing as s_i.
REQ-013 s_ready  out  1  combinational; a group is consumed when s_valid&&s_ready.
REQ-014 word_ack  in  1  one-cycle pulse from the serializer: current word latched.
REQ-015 word  out  FRAME_W  registered word presented to the serializer.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse on completion of a message.

Function
REQ-018 States SHALL be IDLE, PREPARE, TRANSMIT and TAIL; state, word and counters change only in cycles with word_ack=1, except start capture.
REQ-019 A data frame SHALL be {2'b10, I, tI, 2'b01, Q, tQ} with I/Q being SAMPLE_W-bit fields, MSB first.
REQ-020 The end marker SHALL be {2'b10, SAMPLE_W+1 zeros, 2'b01, SAMPLE_W+1 zeros}.
REQ-021 IDLE: word=0. start=1 sets a pending flag; on the next word_ack with the flag set: clear flag, gap_cnt=0, go to PREPARE.
REQ-022 start while busy SHALL be ignored and SHALL NOT set the pending flag.
REQ-023 PREPARE: word=0; each word_ack increments gap_cnt until gap_cnt==GAP_WORDS-1.
REQ-024 s_ready SHALL be (state==PREPARE)&&(gap_cnt==GAP_WORDS-1)&&word_ack.
REQ-025 On consumption, the block SHALL latch all channels and the s_last flag, set ch=0, load word with channel 0's frame, and go to TRANSMIT.
REQ-026 If s_valid=0 when the gap is complete, the block SHALL remain in PREPARE sending zero words until a group arrives (underflow), with no extra gap.
REQ-027 TRANSMIT: on word_ack with ch<NUM_CH-1, ch increments and word loads the next channel's frame.
REQ-028 TRANSMIT, on word_ack at the last channel: if the latched last flag=1, word=end marker and go to TAIL; else word=0, gap_cnt=0, go to PREPARE.
REQ-029 TAIL: on word_ack, word=0, done=1 for one cycle, go to IDLE; start in that same cycle SHALL be ignored.
REQ-030 Latency: word SHALL update in the cycle after the word_ack that causes the change.

Reset
REQ-031 reset_n low SHALL immediately force state=IDLE, word=0, busy=0, done=0, gap_cnt=0, ch=0, and clear the pending and last flags, including mid-message.
REQ-032 After reset release, the first message SHALL require a new start.

Configuration
REQ-033 Macro IQ_FRAME_PACKER_PARITY_EN: when defined, tI=XOR of the I field and tQ=XOR of the Q field.
REQ-034 Without the macro, tI=1 and tQ=0; the end marker SHALL be unaffected in both builds.

Verification (SAMPLE_W=13, NUM_CH=1, GAP_WORDS=8, word_ack every 4 cycles)
REQ-035 Send start, then one group I=13'h0001, Q=13'h1FFF, s_last=1 -> 8 words of 0, then 0x8003_7FFE, then 0x8000_4000, then 0, with done pulsing once and busy returning to 0.
REQ-036 Same stimulus with IQ_FRAME_PACKER_PARITY_EN defined -> data word 0x8003_7FFF; end marker 0x8000_4000.
REQ-037 Withhold s_valid for 5 acks after the gap -> 13 zero words before the data word, and s_ready is never high without word_ack.
REQ-038 NUM_CH=3 with two groups, the second with s_last=1 -> 8 zeros, 3 frames, 8 zeros, 3 frames, end marker; channel order is 0, 1, 2.
REQ-039 Assert reset_n low during TRANSMIT -> word=0, busy=0 in the same cycle; start asserted during busy has no effect afterwards.
REQ-040 Pulse start in the TAIL ack cycle -> no new message begins; a later start begins a message normally.

Source files
------------

// File: rtl/iq_frame_packer.sv
// iq_frame_packer: packs I/Q sample groups into framed words for a
// word-acknowledged serializer. Every message starts with GAP_WORDS zero
// words before each sample group, continues with one frame per channel and
// ends with an end marker word.
//
// Build option: define IQ_FRAME_PACKER_PARITY_EN to carry even-parity bits
// (XOR of the field) in the tI/tQ positions. Without it, tI=1 and tQ=0.
module iq_frame_packer #(
  parameter int SAMPLE_W  = 13,
  parameter int NUM_CH    = 1,
  parameter int GAP_WORDS = 8,
  localparam int FRAME_W  = 2*SAMPLE_W+6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       s_valid,
  input  logic                       s_last,
  input  logic [NUM_CH*SAMPLE_W-1:0] s_i,
  input  logic [NUM_CH*SAMPLE_W-1:0] s_q,
  output logic                       s_ready,
  input  logic                       word_ack,
  output logic [FRAME_W-1:0]         word,
  output logic                       busy,
  output logic                       done
);

  localparam int BUS_W = NUM_CH*SAMPLE_W;
  localparam logic [7:0] GAP_LAST = 8'(GAP_WORDS-1);
  localparam logic [2:0] CH_LAST  = 3'(NUM_CH-1);
  localparam logic [FRAME_W-1:0] END_MARK =
    {2'b10, {(SAMPLE_W+1){1'b0}}, 2'b01, {(SAMPLE_W+1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREPARE  = 2'd1,
    ST_TRANSMIT = 2'd2,
    ST_TAIL     = 2'd3
  } state_t;

  // Even parity over one sample field.
  function automatic logic field_parity(input logic [SAMPLE_W-1:0] f);
    return ^f;
  endfunction

  // Build one data frame from an I/Q pair.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [SAMPLE_W-1:0] i_s,
                                                     input logic [SAMPLE_W-1:0] q_s);
    logic t_i;
    logic t_q;
`ifdef IQ_FRAME_PACKER_PARITY_EN
    t_i = field_parity(i_s);
    t_q = field_parity(q_s);
`else
    t_i = 1'b1;
    t_q = 1'b0;
`endif
    return {2'b10, i_s, t_i, 2'b01, q_s, t_q};
  endfunction

  state_t             state_q, state_d;
  logic               pending_q, pending_d;
  logic [7:0]         gap_cnt_q, gap_cnt_d;
  logic [2:0]         ch_q, ch_d;
  logic               last_q, last_d;
  logic [BUS_W-1:0]   i_lat_q, i_lat_d;
  logic [BUS_W-1:0]   q_lat_q, q_lat_d;
  logic [FRAME_W-1:0] word_q, word_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2:0]         ch_nxt;

  // A group is taken only in the ack cycle that completes the gap.
  assign s_ready = (state_q == ST_PREPARE) && (gap_cnt_q == GAP_LAST) && word_ack;

  assign word = word_q;
  assign busy = busy_q;
  assign done = done_q;

  // Next-state logic: everything advances on word_ack except start capture in IDLE.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    gap_cnt_d = gap_cnt_q;
    ch_d      = ch_q;
    last_d    = last_q;
    i_lat_d   = i_lat_q;
    q_lat_d   = q_lat_q;
    word_d    = word_q;
    done_d    = 1'b0;
    ch_nxt    = ch_q + 3'd1;
    case (state_q)
      ST_IDLE: begin
        word_d = {FRAME_W{1'b0}};
        if (word_ack && pending_q) begin
          pending_d = 1'b0;
          gap_cnt_d = 8'd0;
          state_d   = ST_PREPARE;
        end else if (start) begin
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
      end
      ST_PREPARE: begin
        word_d = {FRAME_W{1'b0}};
        if (word_ack) begin
          if (gap_cnt_q != GAP_LAST) begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end else if (s_valid) begin
            // Underflow simply keeps us here sending zeros, no new gap.
            i_lat_d = s_i;
            q_lat_d = s_q;
            last_d  = s_last;
            ch_d    = 3'd0;
            word_d  = make_frame(s_i[SAMPLE_W-1:0], s_q[SAMPLE_W-1:0]);
            state_d = ST_TRANSMIT;
          end else begin
            state_d = ST_PREPARE;
          end
        end else begin
          state_d = ST_PREPARE;
        end
      end
      ST_TRANSMIT: begin
        if (word_ack) begin
          if (ch_q < CH_LAST) begin
            ch_d   = ch_nxt;
            word_d = make_frame(i_lat_q[int'(ch_nxt)*SAMPLE_W +: SAMPLE_W],
                                q_lat_q[int'(ch_nxt)*SAMPLE_W +: SAMPLE_W]);
          end else if (last_q) begin
            word_d  = END_MARK;
            state_d = ST_TAIL;
          end else begin
            word_d    = {FRAME_W{1'b0}};
            gap_cnt_d = 8'd0;
            state_d   = ST_PREPARE;
          end
        end else begin
          state_d = ST_TRANSMIT;
        end
      end
      ST_TAIL: begin
        // start is deliberately not looked at here.
        if (word_ack) begin
          word_d  = {FRAME_W{1'b0}};
          done_d  = 1'b1;
          last_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TAIL;
        end
      end
      default: begin
        word_d  = {FRAME_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears everything, even mid-message.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      gap_cnt_q <= 8'd0;
      ch_q      <= 3'd0;
      last_q    <= 1'b0;
      i_lat_q   <= {BUS_W{1'b0}};
      q_lat_q   <= {BUS_W{1'b0}};
      word_q    <= {FRAME_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      gap_cnt_q <= gap_cnt_d;
      ch_q      <= ch_d;
      last_q    <= last_d;
      i_lat_q   <= i_lat_d;
      q_lat_q   <= q_lat_d;
      word_q    <= word_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_iq_frame_packer.sv
// Self-checking bench for iq_frame_packer. Two instances: NUM_CH=1 (dut 0)
// and NUM_CH=3 (dut 1). Expected word streams are built per message from the
// framing rules: (GAP + underflow) zeros per group, one frame per channel,
// then the end marker.
module tb_iq_frame_packer;

  localparam int SW  = 13;
  localparam int GAP = 8;
  localparam int FW  = 2*SW+6;
  localparam logic [FW-1:0] END_W = 32'h8000_4000;

  logic clk;
  logic reset_n;
  logic word_ack;
  logic [1:0]              start_v;
  logic [1:0]              s_valid_v;
  logic [1:0]              s_last_v;
  logic [1:0][3*SW-1:0]    s_i_v;
  logic [1:0][3*SW-1:0]    s_q_v;
  logic [1:0]              s_ready_w;
  logic [1:0]              busy_w;
  logic [1:0]              done_w;
  logic [1:0][FW-1:0]      word_w;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt [2];
  logic [FW-1:0] rec_q [$];
  logic [FW-1:0] exp_q [$];
  logic [3*SW-1:0] grp_i [$];
  logic [3*SW-1:0] grp_q [$];
  int grp_u [$];
  bit poke_busy;
  bit poke_tail;

  iq_frame_packer #(.SAMPLE_W(SW), .NUM_CH(1), .GAP_WORDS(GAP)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .s_valid(s_valid_v[0]),
    .s_last(s_last_v[0]), .s_i(s_i_v[0][SW-1:0]), .s_q(s_q_v[0][SW-1:0]),
    .s_ready(s_ready_w[0]), .word_ack(word_ack), .word(word_w[0]),
    .busy(busy_w[0]), .done(done_w[0]));

  iq_frame_packer #(.SAMPLE_W(SW), .NUM_CH(3), .GAP_WORDS(GAP)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .s_valid(s_valid_v[1]),
    .s_last(s_last_v[1]), .s_i(s_i_v[1]), .s_q(s_q_v[1]),
    .s_ready(s_ready_w[1]), .word_ack(word_ack), .word(word_w[1]),
    .busy(busy_w[1]), .done(done_w[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Serializer model: one-cycle ack every fourth cycle.
  initial begin
    word_ack = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      word_ack = 1'b1;
      @(negedge clk);
      word_ack = 1'b0;
    end
  end

  function automatic logic [FW-1:0] ref_frame(input logic [SW-1:0] i_s, input logic [SW-1:0] q_s);
    logic ti;
    logic tq;
`ifdef IQ_FRAME_PACKER_PARITY_EN
    ti = ^i_s;
    tq = ^q_s;
`else
    ti = 1'b1;
    tq = 1'b0;
`endif
    return {2'b10, i_s, ti, 2'b01, q_s, tq};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Monitor: record words latched by the serializer while busy, count done pulses.
  initial begin
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (word_ack && busy_w[k]) rec_q.push_back(word_w[k]);
        if (done_w[k]) done_cnt[k]++;
        vectors++;
        assert (!(s_ready_w[k] && !word_ack)) else begin
          miscompares++;
          $error("FAIL s_ready_without_ack dut%0d observed=%0b expected=0", k, s_ready_w[k]);
        end
      end
    end
  end

  task automatic random_groups(input int k, input int ng);
    logic [63:0] r;
    grp_i.delete(); grp_q.delete(); grp_u.delete();
    for (int g = 0; g < ng; g++) begin
      r = {$urandom(), $urandom()};
      grp_i.push_back(r[3*SW-1:0]);
      r = {$urandom(), $urandom()};
      grp_q.push_back(r[3*SW-1:0]);
      grp_u.push_back(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic run_msg(input int k);
    int nch;
    int base;
    int d0;
    int n;
    int ng;
    int rsz;
    logic [63:0] r;
    nch = (k == 0) ? 1 : 3;
    ng  = grp_i.size();
    d0  = done_cnt[k];
    rec_q.delete();
    exp_q.delete();
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    for (int g = 0; g < ng; g++) begin
      base = exp_q.size();
      repeat (GAP + grp_u[g]) exp_q.push_back('0);
      for (int c = 0; c < nch; c++)
        exp_q.push_back(ref_frame(grp_i[g][c*SW +: SW], grp_q[g][c*SW +: SW]));
      n = 0;
      while (rec_q.size() < base + GAP - 1 + grp_u[g] && n < 2000) begin
        @(negedge clk); #2; n++;
      end
      chk($sformatf("gap_wait dut%0d grp%0d", k, g), 64'(n < 2000), 64'd1);
      if (poke_busy) begin
        start_v[k] = 1'b1;
      end
      @(negedge clk);
      start_v[k]   = 1'b0;
      s_i_v[k]     = grp_i[g];
      s_q_v[k]     = grp_q[g];
      s_last_v[k]  = (g == ng - 1);
      s_valid_v[k] = 1'b1;
      n = 0;
      do begin
        @(negedge clk); #2; n++;
      end while (!s_ready_w[k] && n < 100);
      chk($sformatf("handshake dut%0d grp%0d", k, g), 64'(s_ready_w[k]), 64'd1);
      @(negedge clk);
      s_valid_v[k] = 1'b0;
      r = {$urandom(), $urandom()};
      s_i_v[k] = r[3*SW-1:0];
      r = {$urandom(), $urandom()};
      s_q_v[k] = r[3*SW-1:0];
      s_last_v[k] = r[0];
    end
    exp_q.push_back(END_W);
    if (poke_tail) begin
      n = 0;
      do begin
        @(negedge clk); #2; n++;
      end while (!(word_ack && busy_w[k] && word_w[k] == END_W) && n < 200);
      chk("tail_found", 64'(n < 200), 64'd1);
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
    end
    n = 0;
    while (done_cnt[k] == d0 && n < 2000) begin
      @(negedge clk); #2; n++;
    end
    repeat (6) @(negedge clk);
    #2;
    chk($sformatf("done_pulses dut%0d", k), 64'(done_cnt[k] - d0), 64'd1);
    chk($sformatf("busy_after dut%0d", k), 64'(busy_w[k]), 64'd0);
    chk($sformatf("stream_len dut%0d", k), 64'(rec_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("word[%0d] dut%0d", i, k), (i < rec_q.size()) ? 64'(rec_q[i]) : 64'hx, 64'(exp_q[i]));
    // No stray message may follow (ignored start, or none requested).
    rsz = rec_q.size();
    repeat (28) @(negedge clk);
    #2;
    chk($sformatf("stays_idle dut%0d", k), 64'(busy_w[k]), 64'd0);
    chk($sformatf("no_extra_words dut%0d", k), 64'(rec_q.size()), 64'(rsz));
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start_v = '0; s_valid_v = '0; s_last_v = '0; s_i_v = '0; s_q_v = '0;
    poke_busy = 1'b0; poke_tail = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_word dut%0d", k), 64'(word_w[k]), 64'd0);
      chk($sformatf("rst_busy dut%0d", k), 64'(busy_w[k]), 64'd0);
      chk($sformatf("rst_done dut%0d", k), 64'(done_w[k]), 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    #2;
    chk("idle_without_start", 64'(busy_w), 64'd0);

    // Single group, NUM_CH=1, last.
    grp_i.delete(); grp_q.delete(); grp_u.delete();
    grp_i.push_back(39'h0001); grp_q.push_back(39'h1FFF); grp_u.push_back(0);
    run_msg(0);
    chk("zero_words", 64'((rec_q.size() > GAP) ? rec_q[GAP-1] : 32'hx), 64'd0);
`ifdef IQ_FRAME_PACKER_PARITY_EN
    chk("data_word", 64'((rec_q.size() > GAP) ? rec_q[GAP] : 32'hx), 64'h8003_7FFF);
`else
    chk("data_word", 64'((rec_q.size() > GAP) ? rec_q[GAP] : 32'hx), 64'h8003_7FFE);
`endif
    chk("end_word", 64'((rec_q.size() > GAP+1) ? rec_q[GAP+1] : 32'hx), 64'h8000_4000);

    // Underflow: group withheld 5 acks past the gap.
    grp_u[0] = 5;
    run_msg(0);
    chk("underflow_len", 64'(rec_q.size()), 64'(GAP + 5 + 2));

    // NUM_CH=3, two groups, distinct channel values to expose ordering.
    grp_i.delete(); grp_q.delete(); grp_u.delete();
    grp_i.push_back({13'h0333, 13'h0222, 13'h0111}); grp_q.push_back({13'h1003, 13'h1002, 13'h1001}); grp_u.push_back(0);
    grp_i.push_back({13'h0AAA, 13'h0555, 13'h1234}); grp_q.push_back({13'h0F0F, 13'h00F0, 13'h1FFE}); grp_u.push_back(0);
    run_msg(1);

    // start while busy must be ignored.
    random_groups(1, 2);
    poke_busy = 1'b1;
    run_msg(1);
    poke_busy = 1'b0;

    // start in the TAIL ack cycle is ignored; a later start works.
    grp_i.delete(); grp_q.delete(); grp_u.delete();
    grp_i.push_back(39'h0005); grp_q.push_back(39'h0123); grp_u.push_back(0);
    poke_tail = 1'b1;
    run_msg(0);
    poke_tail = 1'b0;
    random_groups(0, 1);
    run_msg(0);

    // Reset during TRANSMIT.
    rec_q.delete();
    @(negedge clk);
    start_v[1] = 1'b1;
    s_valid_v[1] = 1'b1; s_last_v[1] = 1'b1;
    s_i_v[1] = 39'h12345; s_q_v[1] = 39'h6789A;
    @(negedge clk);
    start_v[1] = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while (word_w[1] == '0 && n < 400);
    chk("reach_transmit", 64'(n < 400), 64'd1);
    start_v[1] = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_word", 64'(word_w[1]), 64'd0);
    chk("midrst_busy", 64'(busy_w[1]), 64'd0);
    chk("midrst_ready", 64'(s_ready_w[1]), 64'd0);
    @(negedge clk);
    start_v[1] = 1'b0; s_valid_v[1] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rec_q.delete();
    repeat (40) @(negedge clk);
    #2;
    chk("post_rst_idle", 64'(busy_w[1]), 64'd0);
    chk("post_rst_no_words", 64'(rec_q.size()), 64'd0);

    // Randomized messages on both instances.
    for (int m = 0; m < 6; m++) begin
      int k;
      k = int'($urandom_range(0, 1));
      random_groups(k, int'($urandom_range(1, 3)));
      run_msg(k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
